// File: rtl/fsm_pkg.sv
// Shared definitions for the result-dump sequencer: state encoding and word geometry.
package fsm_pkg;
  localparam int DEF_ADDR_W     = 5;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CAPT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_e;
endpackage

// File: rtl/word_counter.sv
// Loadable word counter: holds the requested word count and the current word index.
module word_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W:0]   cnt_i,
  input  logic         inc_i,
  output logic [W-1:0] idx_o,
  output logic         last_word_o
);
  logic [W:0] cnt_q, idx_q, idx_nxt;

  assign idx_nxt = idx_q + (W+1)'(1);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      cnt_q <= cnt_i;
      idx_q <= '0;
    end else if (inc_i) begin
      idx_q <= idx_nxt;
    end
  end

  // W+1 bits so a full-memory count (2^W) still terminates after the last index.
  assign idx_o       = idx_q[W-1:0];
  assign last_word_o = (idx_nxt == cnt_q);
endmodule

// File: rtl/fsm_salida.sv
// Dumps a block of data-memory words as a byte stream, MSB first, with a valid/ack handshake.
module fsm_salida
  import fsm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ack,
  output logic              busy,
  output logic              done
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [1:0]          byte_q, byte_d;
  logic [ADDR_W-1:0]   word_idx;
  logic                last_word, cnt_load, word_inc;

  word_counter #(.W(ADDR_W)) u_word_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .cnt_i      (count),
    .inc_i      (word_inc),
    .idx_o      (word_idx),
    .last_word_o(last_word)
  );

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      shift_q <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    cnt_load = 1'b0;
    word_inc = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        base_d   = base_addr;
        cnt_load = 1'b1;
        state_d  = (count != '0) ? S_READ : S_DONE;
      end
      S_READ: state_d = S_CAPT;
      S_CAPT: begin
        shift_d = mem_data;
        byte_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: if (tx_ack) begin
        shift_d = shift_q << 8;
        byte_d  = byte_q + 2'd1;
        if (byte_q == 2'(BYTES_PER_WORD - 1)) begin
          word_inc = 1'b1;
          state_d  = last_word ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs decode from registered state so tx_ack never reaches tx_valid combinationally.
  assign mem_rd   = (state_q == S_READ);
  assign mem_addr = mem_rd ? (base_q + word_idx) : '0;
  assign tx_valid = (state_q == S_SEND);
  assign tx_data  = tx_valid ? shift_q[DATA_W-1 -: 8] : 8'h00;
  assign busy     = (state_q == S_READ) || (state_q == S_CAPT) || (state_q == S_SEND);
  assign done     = (state_q == S_DONE);
endmodule

// File: tb/tb_fsm_salida.sv
// Randomized scoreboard bench for fsm_salida: driver pushes expected reads/bytes, monitor pops and compares.
module tb_fsm_salida;
  localparam int AW = 5;
  localparam int MEM_WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [31:0]   mem_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ack = 1'b0;
  logic          busy, done;

  logic [31:0]   mem [MEM_WORDS];
  int            n_tests = 0, n_fail = 0;
  logic [7:0]    exp_bytes[$];
  logic [AW-1:0] exp_addr[$];
  int            exp_done = 0;

  fsm_salida #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data appears one edge after mem_rd.
  always @(negedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a transfer reads words base..base+c-1 (mod memory size), each sent as 4 bytes MSB first.
  task automatic push_expect(input int b, input int c);
    for (int w = 0; w < c; w++) begin
      int a;
      a = (b + w) % MEM_WORDS;
      exp_addr.push_back(AW'(a));
      for (int k = 0; k < 4; k++) exp_bytes.push_back(8'(mem[a] >> (24 - 8*k)));
    end
    exp_done++;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
    chk({tag, "_tx_data"},  32'(tx_data), 0);
    chk({tag, "_mem_rd"},   32'(mem_rd), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_busy"},     32'(busy), 0);
    chk({tag, "_done"},     32'(done), 0);
  endtask

  // mode 0: ack always; mode 1: ack after 3 low cycles per byte; mode 2: random ack.
  task automatic run_xfer(input int b, input int c, input int mode);
    int  hold;
    bit  seen;
    hold = 0;
    seen = 1'b0;
    @(posedge clk); #1;
    base_addr = AW'(b);
    count     = (AW+1)'(c);
    start     = 1'b1;
    tx_ack    = 1'b0;
    push_expect(b, c);
    for (int iter = 0; iter < 1000; iter++) begin
      @(posedge clk); #1;
      if (iter == 0 && c == 0) chk("zero_count_done_latency", 32'(done), 1);
      if (done) begin
        seen = 1'b1;
        break;
      end
      // Noise on start/base/count while busy must not disturb the transfer.
      start     = 1'($urandom);
      base_addr = AW'($urandom);
      count     = (AW+1)'($urandom);
      case (mode)
        0: tx_ack = 1'b1;
        1: begin
          if (tx_valid) begin
            tx_ack = (hold == 3);
            hold   = (hold == 3) ? 0 : hold + 1;
          end else begin
            tx_ack = 1'b0;
            hold   = 0;
          end
        end
        default: tx_ack = 1'($urandom);
      endcase
    end
    start  = 1'b0;
    tx_ack = 1'b0;
    chk("done_within_budget", 32'(seen), 1);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      tx_ack = 1'($urandom);
    end
    @(posedge clk); #1;
    tx_ack = 1'b0;
  endtask

  initial begin : monitor
    bit         held;
    logic [7:0] held_d;
    int         gap;
    bit         prev_v;
    held = 0; held_d = '0; gap = 0; prev_v = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst) begin
        held = 0; gap = 0; prev_v = 0;
      end else begin
        if (held) begin
          chk("hold_valid", 32'(tx_valid), 1);
          chk("hold_data", 32'(tx_data), 32'(held_d));
        end
        if (mem_rd) begin
          chk("read_expected", 32'(exp_addr.size() > 0), 1);
          if (exp_addr.size() > 0) chk("read_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
        end
        if (tx_valid && !prev_v) chk("gap_before_word", 32'(gap), 2);
        if (!busy || tx_valid) gap = 0;
        else gap++;
        if (tx_valid && tx_ack) begin
          chk("byte_expected", 32'(exp_bytes.size() > 0), 1);
          if (exp_bytes.size() > 0) chk("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
          held = 0;
        end else if (tx_valid) begin
          held = 1; held_d = tx_data;
        end else begin
          held = 0;
        end
        if (done) begin
          chk("done_expected", 32'(exp_done > 0), 1);
          if (exp_done > 0) exp_done--;
          chk("done_busy_low", 32'(busy), 0);
          chk("done_tx_valid_low", 32'(tx_valid), 0);
        end
        prev_v = tx_valid;
      end
    end
  end

  initial begin : driver
    int n;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    mem[3] = 32'hA1B2C3D4;
    run_xfer(3, 1, 0); idle_gap(3);
    run_xfer(3, 1, 1); idle_gap(3);

    mem[31] = 32'h11223344;
    mem[0]  = 32'h55667788;
    run_xfer(31, 2, 0); idle_gap(2);

    run_xfer(7, 0, 2); idle_gap(4);

    // Abort mid-word with reset, then start fresh at base 5.
    @(posedge clk); #1;
    base_addr = AW'(9); count = (AW+1)'(3); start = 1'b1; tx_ack = 1'b1;
    push_expect(9, 3);
    n = 0;
    for (int t = 0; t < 50 && n < 2; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (tx_valid) n++;
    end
    chk("reached_second_byte", 32'(n), 2);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_bytes.delete();
    exp_addr.delete();
    exp_done = 0;
    tx_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_xfer(5, 2, 2); idle_gap(2);

    run_xfer(int'($urandom_range(0, 31)), MEM_WORDS, 0); idle_gap(2);

    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < 4; j++) mem[$urandom_range(0, MEM_WORDS-1)] = $urandom;
      run_xfer(int'($urandom_range(0, 31)), int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
      idle_gap(int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #2;
    chk("bytes_left", 32'(exp_bytes.size()), 0);
    chk("reads_left", 32'(exp_addr.size()), 0);
    chk("dones_left", 32'(exp_done), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
